// File: rtl/pw_pkg.sv
// Shared encodings for the password-lock stimulus driver: FSM states and verdict codes.
package pw_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOCK_RST = 3'd1;
  localparam logic [2:0] ST_PRESS    = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_REPORT   = 3'd4;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_OPEN    = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {WIDTH{1'b1}}))
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pw_entry_driver.sv
// Drives one password attempt into the lock (reset, char, enter press) and records
// the verdict, keeping saturating trial/open tallies for repeated fault-injection runs.
module pw_entry_driver
  import pw_pkg::*;
#(
  parameter int PW_WIDTH       = 8,
  parameter int RST_CYCLES     = 2,
  parameter int PRESS_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 clear_cnt,
  input  logic [PW_WIDTH-1:0]  char_value,
  input  logic                 open_in,
  input  logic                 wrong_in,
  output logic [PW_WIDTH:0]    char_out,
  output logic                 enter_out,
  output logic                 lock_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [CNT_WIDTH-1:0] trial_cnt,
  output logic [CNT_WIDTH-1:0] open_cnt
);

  localparam int MAX_RP = (RST_CYCLES > PRESS_CYCLES) ? RST_CYCLES : PRESS_CYCLES;
  localparam int MAXC   = (MAX_RP > TIMEOUT_CYCLES) ? MAX_RP : TIMEOUT_CYCLES;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [1:0]          verdict_q, verdict_d;
  logic [PW_WIDTH-1:0] char_q, char_d;
  logic                enter_q, lrst_n_q, busy_q, done_q;
  logic [1:0]          result_q;
  logic                rpt_commit, open_commit;

  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    char_d    = char_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOCK_RST;
          char_d  = char_value;
        end
      end
      ST_LOCK_RST: if (cyc_q == RST_LAST)   state_d = ST_PRESS;
      ST_PRESS:    if (cyc_q == PRESS_LAST) state_d = ST_WAIT;
      ST_WAIT: begin
        // Indicators are only trusted here, so stale levels from the last trial are masked.
        if (open_in) begin
          verdict_d = RES_OPEN;
          state_d   = ST_REPORT;
        end else if (wrong_in) begin
          verdict_d = RES_WRONG;
          state_d   = ST_REPORT;
        end else if (cyc_q == TO_LAST) begin
          verdict_d = RES_TIMEOUT;
          state_d   = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE))
      state_d = ST_IDLE;

    if ((state_q == ST_IDLE) || (state_d != state_q))
      cyc_d = '0;
    else
      cyc_d = cyc_q + CW'(1);
  end

  assign rpt_commit  = (state_q == ST_REPORT) && !abort;
  assign open_commit = rpt_commit && (verdict_q == RES_OPEN);

  // Lock-facing strobes follow the state register one cycle later; abort kills them at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      verdict_q <= RES_NONE;
      char_q    <= '0;
      enter_q   <= 1'b0;
      lrst_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= RES_NONE;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      verdict_q <= verdict_d;
      char_q    <= char_d;
      enter_q   <= (state_q == ST_PRESS) && !abort;
      lrst_n_q  <= !((state_q == ST_LOCK_RST) && !abort);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= rpt_commit;
      if (rpt_commit) result_q <= verdict_q;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_trial_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rpt_commit),
    .clr     (clear_cnt),
    .cnt     (trial_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_open_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (open_commit),
    .clr     (clear_cnt),
    .cnt     (open_cnt)
  );

  assign char_out   = {1'b0, char_q};
  assign enter_out  = enter_q;
  assign lock_rst_n = lrst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;

endmodule

// File: tb/tb_pw_entry_driver.sv
// Directed bench for pw_entry_driver; a second instance with 2-bit counters shares all inputs.
module tb_pw_entry_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, abort, clear_cnt, open_in, wrong_in;
  logic [7:0] char_value;

  logic [8:0]  char_out;
  logic        enter_out, lock_rst_n, busy, done;
  logic [1:0]  result;
  logic [15:0] trial_cnt, open_cnt;

  logic [8:0]  c2_char_out;
  logic        c2_enter_out, c2_lock_rst_n, c2_busy, c2_done;
  logic [1:0]  c2_result;
  logic [1:0]  c2_trial_cnt, c2_open_cnt;

  int nvec = 0;
  int nerr = 0;

  pw_entry_driver dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .clear_cnt(clear_cnt),
    .char_value(char_value), .open_in(open_in), .wrong_in(wrong_in),
    .char_out(char_out), .enter_out(enter_out), .lock_rst_n(lock_rst_n), .busy(busy),
    .done(done), .result(result), .trial_cnt(trial_cnt), .open_cnt(open_cnt)
  );

  pw_entry_driver #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .clear_cnt(clear_cnt),
    .char_value(char_value), .open_in(open_in), .wrong_in(wrong_in),
    .char_out(c2_char_out), .enter_out(c2_enter_out), .lock_rst_n(c2_lock_rst_n), .busy(c2_busy),
    .done(c2_done), .result(c2_result), .trial_cnt(c2_trial_cnt), .open_cnt(c2_open_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; clear_cnt = 1'b0;
    open_in = 1'b0; wrong_in = 1'b0; char_value = 8'hFF;
    repeat (3) tick();
    nvec++; if ({busy, done, enter_out, lock_rst_n, result} !== 6'b000100) begin nerr++;
      $display("FAIL reset_ctrl: got %b want %b", {busy, done, enter_out, lock_rst_n, result}, 6'b000100); end
    nvec++; if ({char_out, trial_cnt, open_cnt} !== 41'd0) begin nerr++;
      $display("FAIL reset_data: char %h trial %0d open %0d want 0", char_out, trial_cnt, open_cnt); end
    reset_n = 1'b1;
    tick();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_open;
    logic [3:0] exp;
    char_value = 8'h48;
    launch();
    for (int n = 1; n <= 13; n++) begin
      tick();
      exp = {(n <= 10), (n == 11), (n >= 3 && n <= 6), !(n == 1 || n == 2)};
      nvec++; if ({busy, done, enter_out, lock_rst_n} !== exp) begin nerr++;
        $display("FAIL open_cycle%0d: busy/done/enter/lrst got %b want %b", n, {busy, done, enter_out, lock_rst_n}, exp); end
      if (n == 11) begin
        nvec++; if (result !== 2'b01) begin nerr++; $display("FAIL open_result: got %b want 01", result); end
        nvec++; if (char_out !== 9'h048) begin nerr++; $display("FAIL open_char: got %h want 048", char_out); end
        nvec++; if (trial_cnt !== 16'd1 || open_cnt !== 16'd1) begin nerr++;
          $display("FAIL open_counts: trial %0d open %0d want 1 1", trial_cnt, open_cnt); end
      end
      if (n == 9) open_in = 1'b1;
    end
    open_in = 1'b0;
  endtask

  task automatic test_wrong;
    char_value = 8'h41;
    launch();
    for (int n = 1; n <= 12; n++) begin
      tick();
      nvec++; if (done !== (n == 10)) begin nerr++; $display("FAIL wrong_done_c%0d: got %b want %b", n, done, (n == 10)); end
      if (n == 10) begin
        nvec++; if (result !== 2'b10) begin nerr++; $display("FAIL wrong_result: got %b want 10", result); end
        nvec++; if (char_out !== 9'h041) begin nerr++; $display("FAIL wrong_char: got %h want 041", char_out); end
        nvec++; if (trial_cnt !== 16'd2 || open_cnt !== 16'd1) begin nerr++;
          $display("FAIL wrong_counts: trial %0d open %0d want 2 1", trial_cnt, open_cnt); end
      end
      if (n == 8) wrong_in = 1'b1;
    end
    wrong_in = 1'b0;
  endtask

  task automatic test_timeout;
    open_in = 1'b1; wrong_in = 1'b1;
    launch();
    for (int n = 1; n <= 25; n++) begin
      tick();
      nvec++; if (done !== (n == 23)) begin nerr++; $display("FAIL timeout_done_c%0d: got %b want %b", n, done, (n == 23)); end
      if (n == 23) begin
        nvec++; if (result !== 2'b11) begin nerr++; $display("FAIL timeout_result: got %b want 11", result); end
        nvec++; if (trial_cnt !== 16'd3 || open_cnt !== 16'd1) begin nerr++;
          $display("FAIL timeout_counts: trial %0d open %0d want 3 1", trial_cnt, open_cnt); end
      end
      if (n == 6) begin open_in = 1'b0; wrong_in = 1'b0; end
    end
  endtask

  task automatic test_back_to_back;
    char_value = 8'h5A;
    launch();
    for (int n = 1; n <= 14; n++) begin
      tick();
      nvec++; if ({busy, done} !== {(n <= 10), (n == 11)}) begin nerr++;
        $display("FAIL b2b_c%0d: busy/done got %b want %b", n, {busy, done}, {(n <= 10), (n == 11)}); end
      if (n == 11) begin
        nvec++; if (result !== 2'b01) begin nerr++; $display("FAIL b2b_result: got %b want 01", result); end
        nvec++; if (trial_cnt !== 16'd4 || open_cnt !== 16'd2) begin nerr++;
          $display("FAIL b2b_counts: trial %0d open %0d want 4 2", trial_cnt, open_cnt); end
      end
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
      if (n == 9) begin open_in = 1'b1; wrong_in = 1'b1; end
      if (n == 12) begin open_in = 1'b0; wrong_in = 1'b0; end
    end
  endtask

  task automatic test_abort;
    logic [3:0] exp;
    launch();
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp = {(n <= 4), 1'b0, (n >= 3 && n <= 4), !(n == 1 || n == 2)};
      nvec++; if ({busy, done, enter_out, lock_rst_n} !== exp) begin nerr++;
        $display("FAIL abort_c%0d: busy/done/enter/lrst got %b want %b", n, {busy, done, enter_out, lock_rst_n}, exp); end
      if (n == 4) abort = 1'b1;
      if (n == 5) abort = 1'b0;
    end
    nvec++; if (result !== 2'b01 || trial_cnt !== 16'd4 || open_cnt !== 16'd2) begin nerr++;
      $display("FAIL abort_keep: result %b trial %0d open %0d want 01 4 2", result, trial_cnt, open_cnt); end

    char_value = 8'h33;
    launch();
    repeat (8) tick();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL midwait_busy: got %b want 1", busy); end
    #1 reset_n = 1'b0;
    #1;
    nvec++; if ({busy, done, enter_out, lock_rst_n, result} !== 6'b000100) begin nerr++;
      $display("FAIL async_rst_ctrl: got %b want %b", {busy, done, enter_out, lock_rst_n, result}, 6'b000100); end
    nvec++; if (char_out !== 9'h000 || trial_cnt !== 16'd0 || open_cnt !== 16'd0) begin nerr++;
      $display("FAIL async_rst_data: char %h trial %0d open %0d want 0", char_out, trial_cnt, open_cnt); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation;
    for (int t = 0; t < 5; t++) begin
      char_value = 8'(8'h30 + t);
      launch();
      for (int n = 1; n <= 12; n++) begin
        tick();
        if (n == 9) open_in = 1'b1;
        if (n == 11) open_in = 1'b0;
      end
    end
    nvec++; if (trial_cnt !== 16'd5 || open_cnt !== 16'd5) begin nerr++;
      $display("FAIL sat_wide: trial %0d open %0d want 5 5", trial_cnt, open_cnt); end
    nvec++; if (c2_trial_cnt !== 2'd3 || c2_open_cnt !== 2'd3) begin nerr++;
      $display("FAIL sat_narrow: trial %0d open %0d want 3 3", c2_trial_cnt, c2_open_cnt); end

    launch();
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 11) begin
        nvec++; if (done !== 1'b1 || c2_done !== 1'b1 || result !== 2'b01) begin nerr++;
          $display("FAIL clr_report: done %b done2 %b result %b want 1 1 01", done, c2_done, result); end
        nvec++; if (trial_cnt !== 16'd0 || open_cnt !== 16'd0 || c2_trial_cnt !== 2'd0 || c2_open_cnt !== 2'd0) begin nerr++;
          $display("FAIL clr_counts: %0d %0d %0d %0d want 0 0 0 0", trial_cnt, open_cnt, c2_trial_cnt, c2_open_cnt); end
        clear_cnt = 1'b0;
        open_in = 1'b0;
      end
      if (n == 9) open_in = 1'b1;
      if (n == 10) clear_cnt = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_wrong();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
